// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parameterised UART transmitter, one baud_clk cycle per bit.
//            Define UART_TX_FIFO_EN to queue up to FIFO_DEPTH words.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 uart_tx
);

  localparam int            c_CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(DATA_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_STOP = c_CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_BITS-1:0] r_hold, r_shift, w_shift_nxt, w_next_word;
  logic                 w_load, w_wr, w_done, w_next_avail, w_par;

  assign w_wr    = en && ready;
  assign w_done  = (r_state == S_STOP) && (r_cnt == c_LAST_STOP);
  assign w_par   = (PARITY == 1) ? ~(^r_hold) : (^r_hold);
  assign busy    = (r_state != S_IDLE);
  assign uart_tx = r_tx;

`ifdef UART_TX_FIFO_EN
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_QCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_rd, r_wr, w_rd_pop;
  logic [c_QCNT_W-1:0]  r_count, w_count_pop;

  // The head entry is the word on the line; it is popped when its frame ends.
  assign w_rd_pop     = r_rd + c_PTR_W'(w_done);
  assign w_count_pop  = r_count - c_QCNT_W'(w_done);
  assign ready        = (r_count != c_QCNT_W'(FIFO_DEPTH)) || w_done;
  assign w_next_avail = (w_count_pop != '0) || w_wr;
  assign w_next_word  = (w_count_pop != '0) ? r_mem[w_rd_pop] : data;

  always_ff @(posedge baud_clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= data;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + c_PTR_W'(1);
      end
      r_rd    <= w_rd_pop;
      r_count <= w_count_pop + c_QCNT_W'(w_wr);
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (FIFO_DEPTH != 0);
  assign ready        = (r_state == S_IDLE);
  assign w_next_avail = w_wr;
  assign w_next_word  = data;
`endif

  // Next-state logic also produces the next line level so uart_tx is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_next_avail) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
          w_load      = 1'b1;
        end
      end
      S_START: begin
        w_state_nxt = S_DATA;
        w_tx_nxt    = r_hold[0];
        w_shift_nxt = r_hold >> 1;
        w_cnt_nxt   = '0;
      end
      S_DATA: begin
        if (r_cnt == c_LAST_DATA) begin
          if (PARITY != 0) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = w_par;
          end else begin
            w_state_nxt = S_STOP;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
      S_PARITY: begin
        w_state_nxt = S_STOP;
        w_cnt_nxt   = '0;
      end
      S_STOP: begin
        if (w_done) begin
          if (w_next_avail) begin
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      if (w_load) begin
        r_hold <= w_next_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit queue entries (power of 2, >=2; used only with UART_TX_FIFO_EN).
REQ-005 SHALL have port baud_clk  input  1  bit clock; one bit period per cycle; sole clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous to baud_clk, active-high.
REQ-007 SHALL have port en  input  1  write strobe; data accepted on a rising baud_clk edge when en and ready are both high.
REQ-008 SHALL have port data  input  DATA_BITS  word to transmit, LSB sent first.
REQ-009 SHALL have port ready  output  1  high when a word can be accepted this cycle.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high, registered.

Function
REQ-012 SHALL transmit each frame as: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1), one baud_clk cycle per bit.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START when a word is queued; START->DATA; DATA->PARITY after bit DATA_BITS-1 if PARITY!=0, else DATA->STOP; PARITY->STOP; STOP->START if another word is queued, else STOP->IDLE after the last stop bit.
REQ-014 SHALL compute parity over the data bits only: even mode drives the XOR of the bits, odd mode drives its inverse.
REQ-015 SHALL drive the start bit on uart_tx in the cycle after the accepting edge when idle and the queue is empty (latency 1 cycle).
REQ-016 SHALL send back-to-back frames with no idle cycle between the last stop bit and the next start bit.
REQ-017 SHALL assert busy in every cycle in which uart_tx carries a start, data, parity or stop bit, and deassert it in IDLE.
REQ-018 SHALL ignore en when ready is low, with no state change and no corruption of queued data.
REQ-019 SHALL accept a write made in the same cycle a frame completes, including when the queue is full and one entry is popped in that cycle.
REQ-020 SHALL count bit positions with a counter of width clog2(DATA_BITS+1) and wrap queue pointers modulo FIFO_DEPTH.

Reset
REQ-021 SHALL, while rst is high at an edge, force state IDLE, uart_tx=1, busy=0, ready=1, and empty the queue, regardless of any frame in progress.
REQ-022 SHALL give rst priority over en in the same cycle; the word presented is discarded.
REQ-023 SHALL drop a frame interrupted by reset mid-transmission, with the line returning high in the cycle after the reset edge.

Configuration
REQ-024 SHALL, when macro UART_TX_FIFO_EN is defined, buffer up to FIFO_DEPTH words, with ready = queue not full.
REQ-025 SHALL, when UART_TX_FIFO_EN is undefined, use a single holding register plus the shift register, with ready = !busy and no storage beyond the frame in flight.

Verification
REQ-026 SHALL cover: defaults, rst then en pulse with data=0x55 -> uart_tx over the next 10 cycles = 0,1,0,1,0,1,0,1,0,1, then idle 1, busy high for exactly 10 cycles.
REQ-027 SHALL cover: PARITY=2, STOP_BITS=2, data=0x07 -> frame 0,1,1,1,0,0,0,0,0,1,1,1 (parity 1), busy high for 12 cycles.
REQ-028 SHALL cover: UART_TX_FIFO_EN, FIFO_DEPTH=4, five consecutive writes 0x01..0x05 -> ready low after the 4th accepted while frame 1 is active, four frames contiguous with no idle gap, fifth write retried and sent once ready rises.
REQ-029 SHALL cover: rst asserted at data bit 3 of 0xA5 -> uart_tx=1, busy=0, ready=1 the next cycle and no remaining bits emitted.
REQ-030 SHALL cover: UART_TX_FIFO_EN undefined, en held high with changing data during a frame -> only words presented while ready=1 are transmitted.
REQ-031 SHALL cover: DATA_BITS=5, PARITY=1, data=0x1F -> frame 0,1,1,1,1,1,0,1 (odd parity 0).
